// File: rtl/sd_multi_sec_rd_ctrl_if.sv
// SD controller single-sector read port: start/address towards the controller,
// busy and read data back from it.
interface sd_multi_sec_rd_ctrl_if;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_busy;
  logic        rd_val_en;
  logic [15:0] rd_val_data;

  modport master (
    output rd_start_en,
    output rd_sec_addr,
    input  rd_busy,
    input  rd_val_en,
    input  rd_val_data
  );

  modport slave (
    input  rd_start_en,
    input  rd_sec_addr,
    output rd_busy,
    output rd_val_en,
    output rd_val_data
  );
endinterface

// File: rtl/sd_multi_sec_rd_ctrl.sv
// Multi-sector read sequencer on top of the single-sector SD read port.
// Optional feature: define SD_RD_TIMEOUT_EN to bound how long rd_busy may stay high per sector.
module sd_multi_sec_rd_ctrl #(
  parameter int unsigned WORDS_PER_SEC = 256,
  parameter int unsigned BUSY_WAIT     = 16,
  parameter int unsigned TIMEOUT_CYC   = 1048576
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        start,
  input  logic [31:0] start_sec,
  input  logic [15:0] sec_cnt,
  input  logic        fifo_afull,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] sec_done,
  output logic        out_valid,
  output logic [15:0] out_data,
  sd_multi_sec_rd_ctrl_if.master sd
);

  localparam int WC_W = $clog2(WORDS_PER_SEC + 2);
  localparam int BW_W = $clog2(BUSY_WAIT + 1);
  localparam logic [WC_W-1:0] WC_MAX  = WC_W'(WORDS_PER_SEC + 1);
  localparam logic [WC_W-1:0] WC_FULL = WC_W'(WORDS_PER_SEC);
  localparam logic [BW_W-1:0] BW_LAST = BW_W'(BUSY_WAIT - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ROOM     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT_BSY = 3'd3;
  localparam logic [2:0] S_XFER     = 3'd4;
  localparam logic [2:0] S_CHECK    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]      state_q, state_d;
  logic            err_q, err_d;
  logic [15:0]     sec_done_q, sec_done_d;
  logic [15:0]     sec_cnt_q, sec_cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [WC_W-1:0] word_cnt_q, word_cnt_d;
  logic [BW_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_data_q, out_data_d;
`ifdef SD_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign sec_done       = sec_done_q;
  assign sd.rd_start_en = (state_q == S_ISSUE);
  assign sd.rd_sec_addr = addr_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    sec_done_d  = sec_done_q;
    sec_cnt_d   = sec_cnt_q;
    addr_d      = addr_q;
    word_cnt_d  = word_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    out_valid_d = sd.rd_val_en;
    out_data_d  = sd.rd_val_data;
`ifdef SD_RD_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    // Words landing before the busy rise is noticed still belong to this sector.
    if ((state_q == S_WAIT_BSY || state_q == S_XFER) && sd.rd_val_en && word_cnt_q != WC_MAX)
      word_cnt_d = word_cnt_q + WC_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start && sd_init_done) begin
          err_d      = 1'b0;
          sec_done_d = '0;
          addr_d     = start_sec;
          sec_cnt_d  = sec_cnt;
          state_d    = (sec_cnt == 16'd0) ? S_DONE : S_ROOM;
        end
      end
      S_ROOM: begin
        if (!fifo_afull && !sd.rd_busy)
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        word_cnt_d = '0;
        wait_cnt_d = '0;
`ifdef SD_RD_TIMEOUT_EN
        to_cnt_d   = '0;
`endif
        state_d    = S_WAIT_BSY;
      end
      S_WAIT_BSY: begin
        if (sd.rd_busy) begin
          state_d = S_XFER;
        end else if (wait_cnt_q == BW_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + BW_W'(1);
        end
      end
      S_XFER: begin
        if (!sd.rd_busy) begin
          state_d = S_CHECK;
`ifdef SD_RD_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end
      S_CHECK: begin
        if (word_cnt_q != WC_FULL) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          sec_done_d = sec_done_q + 16'd1;
          addr_d     = addr_q + 32'd1;
          state_d    = (sec_done_q + 16'd1 == sec_cnt_q) ? S_DONE : S_ROOM;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Card loss overrides whatever the current state decided.
    if (busy && !sd_init_done) begin
      err_d      = 1'b1;
      sec_done_d = sec_done_q;
      addr_d     = addr_q;
      state_d    = S_DONE;
    end
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      err_q       <= 1'b0;
      sec_done_q  <= '0;
      sec_cnt_q   <= '0;
      addr_q      <= '0;
      word_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef SD_RD_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      sec_done_q  <= sec_done_d;
      sec_cnt_q   <= sec_cnt_d;
      addr_q      <= addr_d;
      word_cnt_q  <= word_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef SD_RD_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sd_multi_sec_rd_ctrl.sv
// Bench for sd_multi_sec_rd_ctrl: SD card responder, job vector table, random jobs
// against a sector-level reference model, and hand-written corner sequences.
module tb_sd_multi_sec_rd_ctrl;

  localparam int WORDS     = 256;
  localparam int BUSY_WAIT = 16;

  typedef struct {
    logic [31:0] start_sec;
    logic [15:0] sec_cnt;
    int          bad_idx;
    int          bad_words;
    int          dead_idx;
    int          exp_issued;
    int          exp_sec_done;
    bit          exp_err;
  } job_t;

  logic        clk_ref = 1'b0;
  logic        rst_n;
  logic        sd_init_done;
  logic        start;
  logic [31:0] start_sec;
  logic [15:0] sec_cnt;
  logic        fifo_afull;
  logic        busy, done, err;
  logic [15:0] sec_done;
  logic        out_valid;
  logic [15:0] out_data;

  bit          force_afull = 1'b0;
  bit          rand_afull  = 1'b0;
  bit          rand_bit    = 1'b0;

  int          checks = 0;
  int          errors = 0;

  int          cfg_bad_idx   = -1;
  int          cfg_bad_words = WORDS;
  int          cfg_dead_idx  = -1;
  int          sec_idx       = 0;
  logic [31:0] issued_addr[$];
  time         issue_time = 0;
  time         done_time  = 0;

  job_t        vec[6];

  sd_multi_sec_rd_ctrl_if sd_if ();

  sd_multi_sec_rd_ctrl #(
    .WORDS_PER_SEC(WORDS),
    .BUSY_WAIT    (BUSY_WAIT),
    .TIMEOUT_CYC  (1048576)
  ) dut (
    .clk_ref     (clk_ref),
    .rst_n       (rst_n),
    .sd_init_done(sd_init_done),
    .start       (start),
    .start_sec   (start_sec),
    .sec_cnt     (sec_cnt),
    .fifo_afull  (fifo_afull),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .sec_done    (sec_done),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .sd          (sd_if)
  );

  always #5 clk_ref = ~clk_ref;

  assign fifo_afull = force_afull | rand_bit;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sector-level model: each sector either completes or ends the job with an error.
  function automatic void refModel(input job_t j, output int n_issued, output int n_done, output bit e);
    n_issued = 0;
    n_done   = 0;
    e        = 1'b0;
    for (int i = 0; i < int'(j.sec_cnt); i++) begin
      n_issued++;
      if (i == j.dead_idx || (i == j.bad_idx && j.bad_words != WORDS)) begin
        e = 1'b1;
        break;
      end
      n_done++;
    end
  endfunction

  task automatic applyStimulus(input logic [31:0] s_sec, input logic [15:0] s_cnt);
    @(negedge clk_ref);
    start     = 1'b1;
    start_sec = s_sec;
    sec_cnt   = s_cnt;
    @(negedge clk_ref);
    start     = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles, output bit seen, output bit busy_seen);
    seen      = 1'b0;
    busy_seen = 1'b0;
    cycles    = 0;
    for (int i = 0; i < budget; i++) begin
      if (busy) busy_seen = 1'b1;
      if (done) begin
        seen      = 1'b1;
        cycles    = i;
        done_time = $time;
        break;
      end
      @(negedge clk_ref);
    end
    if (!seen) checkOutput("done_timeout", 32'(seen), 32'd1);
  endtask

  task automatic waitSecDone(input logic [15:0] target, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sec_done == target) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk_ref);
    end
    if (!hit) checkOutput("sec_done_timeout", 32'(sec_done), 32'(target));
  endtask

  task automatic runJob(input job_t j, input bit use_model);
    int n_issued, n_done, cyc;
    bit e, seen, bs;
    if (use_model) refModel(j, n_issued, n_done, e);
    else begin
      n_issued = j.exp_issued;
      n_done   = j.exp_sec_done;
      e        = j.exp_err;
    end
    cfg_bad_idx   = j.bad_idx;
    cfg_bad_words = j.bad_words;
    cfg_dead_idx  = j.dead_idx;
    sec_idx       = 0;
    issued_addr.delete();
    applyStimulus(j.start_sec, j.sec_cnt);
    waitDone(1000 + int'(j.sec_cnt) * 800, cyc, seen, bs);
    if (seen) begin
      checkOutput("sec_done", 32'(sec_done), 32'(n_done));
      checkOutput("err", 32'(err), 32'(e));
      checkOutput("busy_at_done", 32'(busy), 32'd0);
    end
    checkOutput("issued", 32'(issued_addr.size()), 32'(n_issued));
    for (int i = 0; i < n_issued && i < issued_addr.size(); i++)
      checkOutput("rd_sec_addr", issued_addr[i], j.start_sec + 32'(i));
    if (j.sec_cnt == 16'd0) begin
      checkOutput("zero_job_busy_seen", 32'(bs), 32'd0);
      checkOutput("zero_job_done_latency", 32'(cyc), 32'd0);
    end
    @(negedge clk_ref);
    checkOutput("done_single_pulse", 32'(done), 32'd0);
  endtask

  // SD controller model: busy rises 1-4 cycles after the start pulse, words stream with gaps.
  initial begin : sd_model
    int idx, nwords, sent;
    sd_if.rd_busy     = 1'b0;
    sd_if.rd_val_en   = 1'b0;
    sd_if.rd_val_data = '0;
    forever begin
      @(negedge clk_ref);
      sd_if.rd_val_data = 16'($urandom);
      if (rst_n && sd_if.rd_start_en) begin
        issued_addr.push_back(sd_if.rd_sec_addr);
        issue_time = $time;
        idx        = sec_idx;
        sec_idx++;
        if (idx != cfg_dead_idx) begin
          nwords = (idx == cfg_bad_idx) ? cfg_bad_words : WORDS;
          repeat ($urandom_range(1, 4)) @(negedge clk_ref);
          sd_if.rd_busy = 1'b1;
          sent = 0;
          while (sent < nwords) begin
            @(negedge clk_ref);
            sd_if.rd_val_data = 16'($urandom);
            if ($urandom_range(0, 7) != 0) begin
              sd_if.rd_val_en = 1'b1;
              sent++;
            end else begin
              sd_if.rd_val_en = 1'b0;
            end
          end
          @(negedge clk_ref);
          sd_if.rd_val_en = 1'b0;
          sd_if.rd_busy   = 1'b0;
        end
      end
    end
  end

  initial begin : afull_gen
    forever begin
      @(negedge clk_ref);
      rand_bit = rand_afull && ($urandom_range(0, 3) == 0);
    end
  end

  // Output stage must be a plain one-cycle register of the read data port.
  initial begin : fwd_monitor
    logic        v, r;
    logic [15:0] d;
    forever begin
      @(posedge clk_ref);
      v = sd_if.rd_val_en;
      d = sd_if.rd_val_data;
      r = rst_n;
      #1;
      if (r && rst_n) begin
        checkOutput("fwd_valid", 32'(out_valid), 32'(v));
        checkOutput("fwd_data", 32'(out_data), 32'(d));
      end
    end
  end

  initial begin : watchdog
    #3000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : main
    int cnt_done, cnt_busy, cyc;
    bit seen, bs;
    job_t j;

    rst_n        = 1'b0;
    sd_init_done = 1'b1;
    start        = 1'b0;
    start_sec    = '0;
    sec_cnt      = '0;

    vec[0] = '{32'h0000_0100, 16'd3, -1, WORDS, -1, 3, 3, 1'b0};
    vec[1] = '{32'hFFFF_FFFF, 16'd2, -1, WORDS, -1, 2, 2, 1'b0};
    vec[2] = '{32'h0000_0010, 16'd1,  0, 255,   -1, 1, 0, 1'b1};
    vec[3] = '{32'h0000_0020, 16'd3,  1, 258,   -1, 2, 1, 1'b1};
    vec[4] = '{32'h0000_0030, 16'd2, -1, WORDS,  0, 1, 0, 1'b1};
    vec[5] = '{32'h0000_0040, 16'd0, -1, WORDS, -1, 0, 0, 1'b0};

    repeat (3) @(negedge clk_ref);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_sec_done", 32'(sec_done), 32'd0);
    checkOutput("rst_rd_start_en", 32'(sd_if.rd_start_en), 32'd0);
    checkOutput("rst_rd_sec_addr", sd_if.rd_sec_addr, 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_ref);

    $display("[TB] start without sd_init_done");
    sd_init_done = 1'b0;
    issued_addr.delete();
    applyStimulus(32'h700, 16'd2);
    cnt_done = 0;
    cnt_busy = 0;
    repeat (20) begin
      if (done) cnt_done++;
      if (busy) cnt_busy++;
      @(negedge clk_ref);
    end
    checkOutput("noinit_done", 32'(cnt_done), 32'd0);
    checkOutput("noinit_busy", 32'(cnt_busy), 32'd0);
    checkOutput("noinit_err", 32'(err), 32'd0);
    checkOutput("noinit_issued", 32'(issued_addr.size()), 32'd0);
    sd_init_done = 1'b1;

    $display("[TB] job vector table");
    for (int i = 0; i < 6; i++) begin
      runJob(vec[i], 1'b0);
      if (vec[i].dead_idx >= 0)
        checkOutput("busy_wait_latency", 32'((done_time - issue_time) / 10), 32'(BUSY_WAIT + 1));
    end

    $display("[TB] fifo_afull hold between sectors, start while busy");
    cfg_bad_idx  = -1;
    cfg_dead_idx = -1;
    sec_idx      = 0;
    issued_addr.delete();
    applyStimulus(32'h800, 16'd2);
    waitSecDone(16'd1, 2000);
    force_afull = 1'b1;
    applyStimulus(32'h999, 16'd5);
    repeat (500) @(negedge clk_ref);
    checkOutput("afull_hold_issued", 32'(issued_addr.size()), 32'd1);
    checkOutput("afull_hold_busy", 32'(busy), 32'd1);
    force_afull = 1'b0;
    waitDone(2000, cyc, seen, bs);
    checkOutput("afull_sec_done", 32'(sec_done), 32'd2);
    checkOutput("afull_err", 32'(err), 32'd0);
    checkOutput("afull_issued", 32'(issued_addr.size()), 32'd2);
    if (issued_addr.size() == 2)
      checkOutput("afull_addr1", issued_addr[1], 32'h801);
    @(negedge clk_ref);

    $display("[TB] sd_init_done drop mid-job");
    sec_idx = 0;
    issued_addr.delete();
    applyStimulus(32'h600, 16'd3);
    waitSecDone(16'd1, 2000);
    sd_init_done = 1'b0;
    @(negedge clk_ref);
    checkOutput("initdrop_done", 32'(done), 32'd1);
    checkOutput("initdrop_err", 32'(err), 32'd1);
    checkOutput("initdrop_sec_done", 32'(sec_done), 32'd1);
    checkOutput("initdrop_issued", 32'(issued_addr.size()), 32'd1);
    sd_init_done = 1'b1;
    @(negedge clk_ref);
    checkOutput("initdrop_done_pulse", 32'(done), 32'd0);

    $display("[TB] random jobs against reference model");
    for (int r = 0; r < 16; r++) begin
      j.start_sec = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2)))
                                                : 32'($urandom);
      j.sec_cnt   = 16'($urandom_range(0, 3));
      j.bad_idx   = -1;
      j.bad_words = WORDS;
      j.dead_idx  = -1;
      j.exp_issued   = 0;
      j.exp_sec_done = 0;
      j.exp_err      = 1'b0;
      if (j.sec_cnt != 16'd0 && $urandom_range(0, 3) == 0) begin
        j.bad_idx = int'($urandom_range(0, int'(j.sec_cnt) - 1));
        case ($urandom_range(0, 2))
          0:       j.bad_words = 255;
          1:       j.bad_words = 257;
          default: j.bad_words = 300;
        endcase
      end
      if (j.sec_cnt != 16'd0 && $urandom_range(0, 7) == 0)
        j.dead_idx = int'($urandom_range(0, int'(j.sec_cnt) - 1));
      rand_afull = 1'b1;
      runJob(j, 1'b1);
      rand_afull = 1'b0;
    end

    $display("[TB] reset during a job");
    cfg_bad_idx  = -1;
    cfg_dead_idx = -1;
    sec_idx      = 0;
    issued_addr.delete();
    repeat (2) @(negedge clk_ref);
    applyStimulus(32'hA00, 16'd3);
    waitSecDone(16'd1, 2000);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_sec_done", 32'(sec_done), 32'd0);
    checkOutput("midrst_rd_sec_addr", sd_if.rd_sec_addr, 32'd0);
    repeat (2) @(negedge clk_ref);
    rst_n = 1'b1;
    cnt_done = 0;
    cnt_busy = 0;
    repeat (10) begin
      @(negedge clk_ref);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    checkOutput("midrst_no_done", 32'(cnt_done), 32'd0);
    checkOutput("midrst_idle", 32'(cnt_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
